sa_operand_serializer: RTL and testbench
========================================

// Module: sa_operand_serializer
// PURPOSE
//  Upstream feeder for the bit-serial adder (sa). Accepts two parallel WIDTH-bit operands and a carry-in
//  over a valid/ready handshake. Clears the adder, then shifts the operands out LSB-first, one bit pair
//  per clock, with carry-in driven only on bit 0. Flags bit timing so a downstream collector can capture s/cout.
// PARAMETERS
//  WIDTH    4    operand width in bits (>=2)
// PORTS
//  clk        in   1      rising-edge clock; the only clock in the block
//  reset_n    in   1      asynchronous, active-low reset
//  in_valid   in   1      operand word valid
//  in_ready   out  1      block can accept a word
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  op_cin     in   1      carry-in for bit 0
//  flush      in   1      synchronous abort; returns block to IDLE
//  sa_clr     out  1      active-high clear, drives the adder's reset input
//  sa_a       out  1      serial A bit to adder
//  sa_b       out  1      serial B bit to adder
//  sa_cin     out  1      serial carry-in to adder
//  bit_valid  out  1      sa_a/sa_b/sa_cin carry a live bit this cycle
//  last_bit   out  1      final serial bit this cycle
//  done       out  1      1-cycle pulse; the adder's cout is final
// BEHAVIOUR
//  - Outputs are registered. On reset_n low, all outputs are 0 except sa_clr=1 and in_ready=0.
//    The state machine goes to IDLE. in_ready rises in the first cycle after reset_n is released.
//  - State machine: IDLE -> CLR -> SHIFT -> DONE -> IDLE.
//  - IDLE: in_ready=1. A word transfers when in_valid&in_ready: op_a/op_b load into shift regs,
//    op_cin loads into cin_q, the bit counter clears, and the next state is CLR.
//  - CLR: exactly 1 cycle. sa_clr=1, in_ready=0, bit_valid=0, sa_a=sa_b=sa_cin=0.
//  - SHIFT: NBITS cycles. sa_a=sh_a[0], sa_b=sh_b[0], sa_cin=(cnt==0)?cin_q:0.
//    bit_valid=1 and sa_clr=0. Both shift regs shift right and cnt increments each cycle.
//    last_bit=1 when cnt==NBITS-1. The state after the last bit is DONE.
//  - DONE: 1 cycle. done=1, bit_valid=0, serial outputs 0, next state IDLE.
//  - Latency and throughput: the first bit appears 2 cycles after acceptance.
//    One operation takes NBITS+3 cycles from accept to the next in_ready.
//  - in_valid outside IDLE is ignored. The operands are held only in the shift regs,
//    so upstream may change op_* after the handshake.
//  - flush (sync) from any non-IDLE state: next cycle is IDLE with in_ready=1, and sa_clr=1 for that
//    one cycle. No done pulse. The partial bits are discarded.
//    flush in IDLE wins over in_valid; no word is accepted that cycle.
//  - Async reset mid-operation: abandon the operation immediately; behave as described for reset above.
//  - Counter width is $clog2(NBITS+1). Wrap to 0 is unreachable because the state exits at NBITS-1.
// CONFIGURATION
//  - SA_SER_SIGN_EXT_EN defined: operands are two's complement and NBITS=WIDTH+1.
//    The extra final bit replicates each operand's MSB (op_a[WIDTH-1], op_b[WIDTH-1]).
//    The adder then yields a correct WIDTH+1-bit signed sum on s, and cout is ignored downstream.
//  - SA_SER_SIGN_EXT_EN undefined: unsigned operation with NBITS=WIDTH. The sum is WIDTH bits on s, with cout as bit WIDTH.
// STRUCTURE
//  - Package sa_pkg holds the state enum (ST_IDLE, ST_CLR, ST_SHIFT, ST_DONE), a localparam
//    NBITS computed from the macro, and CNT_W=$clog2(NBITS+1). It is shared with the downstream collector.
//  - Sub-module sa_piso: parallel-load, right-shift register (load, shift, d[NBITS-1:0], q0) with async active-low reset.
//    Instantiated twice, for A and B. The FSM, counter and cin_q live in the top module.
// TESTING
//  1. WIDTH=4, A=1111 B=1101 cin=1. Expect cycles: accept, 1 CLR, 4 SHIFT, then done.
//     (sa_a,sa_b,sa_cin) = 111,100,110,110. last_bit on the 4th bit. Sum from adder = 11101.
//  2. WIDTH=5, A=11011 B=10001 cin=1. Expect serial pairs 111,100,000,100,110, then done.
//     The collector reads 101101.
//  3. Hold in_valid high continuously with two words. Expect the second word accepted only in the IDLE
//     cycle after done, with a spacing of exactly NBITS+3 cycles. The first word's bits are unaffected.
//  4. flush on the 2nd SHIFT cycle. Expect the next cycle to show IDLE, in_ready=1, sa_clr=1,
//     bit_valid=0, and no done pulse. A new word then runs normally.
//  5. reset_n low for 1 cycle mid-SHIFT. Expect outputs to zero asynchronously, with sa_clr=1.
//     After release, in_ready=1 and there is no done pulse.
//  6. SA_SER_SIGN_EXT_EN, WIDTH=4, A=1111(-1) B=0011(+3) cin=0. Expect 5 bits: 110,110,100,100,100.
//     The sum is 00010 (+2).

Source files
------------

// File: rtl/sa_operand_serializer_pkg.sv
// sa_pkg: shared FSM states and serial length for the bit-serial adder feeder and its collector.
// Define SA_SER_SIGN_EXT_EN for two's-complement operands, which adds one sign bit to each serial word.
package sa_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CLR, ST_SHIFT, ST_DONE} state_e;
  localparam int SA_WIDTH = 4;
  function automatic int nbits_f(input int w);
`ifdef SA_SER_SIGN_EXT_EN
    return w + 1;
`else
    return w;
`endif
  endfunction
  localparam int NBITS = nbits_f(SA_WIDTH);
  localparam int CNT_W = $clog2(NBITS + 1);
endpackage

// File: rtl/sa_operand_serializer_if.sv
// sa_operand_serializer_if: operand word handshake.
// Signals: in_valid, in_ready, op_a/op_b (WIDTH), op_cin. Modports: master (producer), slave (serializer).
interface sa_operand_serializer_if #(parameter int WIDTH = 4) ();
  logic in_valid, in_ready, op_cin;
  logic [WIDTH-1:0] op_a, op_b;
  modport master(output in_valid, op_a, op_b, op_cin, input in_ready);
  modport slave(input in_valid, op_a, op_b, op_cin, output in_ready);
endinterface

// File: rtl/sa_operand_serializer_piso.sv
// sa_piso: parallel-load right-shift register exposing its LSB.
// Ports: clk, reset_n (async active-low), load, shift, d[N-1:0], q0.
module sa_piso #(parameter int N = 4) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] d,
  output logic         q0
);
  logic [N-1:0] sh_q, sh_d;
  always_comb sh_d = load ? d : shift ? sh_q >> 1 : sh_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sh_q <= '0;
    else sh_q <= sh_d;
  assign q0 = sh_q[0];
endmodule

// File: rtl/sa_operand_serializer.sv
// sa_operand_serializer: feeds a bit-serial adder LSB-first from a parallel operand handshake.
// Ports: clk, reset_n (async active-low), in_if (slave: in_valid/in_ready/op_a/op_b/op_cin),
// flush (sync abort), sa_clr/sa_a/sa_b/sa_cin to the adder, bit_valid/last_bit/done for the collector.
// SA_SER_SIGN_EXT_EN: append a replicated MSB so the adder yields a WIDTH+1-bit signed sum.
module sa_operand_serializer import sa_pkg::*; #(parameter int WIDTH = 4) (
  input  logic                  clk,
  input  logic                  reset_n,
  sa_operand_serializer_if.slave in_if,
  input  logic                  flush,
  output logic                  sa_clr,
  output logic                  sa_a,
  output logic                  sa_b,
  output logic                  sa_cin,
  output logic                  bit_valid,
  output logic                  last_bit,
  output logic                  done
);
  localparam int N = nbits_f(WIDTH);
  localparam int CW = $clog2(N + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cin_q, cin_d, in_ready_q, in_ready_d, sa_clr_q, sa_clr_d, sa_a_q, sa_a_d, sa_b_q, sa_b_d;
  logic sa_cin_q, sa_cin_d, bit_valid_q, bit_valid_d, last_bit_q, last_bit_d, done_q, done_d;
  logic accept, emit, a0, b0;
  logic [N-1:0] da, db;
`ifdef SA_SER_SIGN_EXT_EN
  assign da = {in_if.op_a[WIDTH-1], in_if.op_a};
  assign db = {in_if.op_b[WIDTH-1], in_if.op_b};
`else
  assign da = in_if.op_a;
  assign db = in_if.op_b;
`endif
  assign accept = state_q == ST_IDLE && in_if.in_valid && in_ready_q && !flush;
  sa_piso #(.N(N)) u_piso_a (.clk(clk), .reset_n(reset_n), .load(accept), .shift(emit), .d(da), .q0(a0));
  sa_piso #(.N(N)) u_piso_b (.clk(clk), .reset_n(reset_n), .load(accept), .shift(emit), .d(db), .q0(b0));
  // Outputs are registered, so each branch computes what the state being entered presents.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cin_d = cin_q;
    emit = 1'b0;
    in_ready_d = 1'b0;
    sa_clr_d = 1'b0;
    sa_a_d = 1'b0;
    sa_b_d = 1'b0;
    sa_cin_d = 1'b0;
    bit_valid_d = 1'b0;
    last_bit_d = 1'b0;
    done_d = 1'b0;
    if (flush && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      in_ready_d = 1'b1;
      sa_clr_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_d = !accept;
          sa_clr_d = accept;
          state_d = accept ? ST_CLR : ST_IDLE;
          cnt_d = accept ? '0 : cnt_q;
          cin_d = accept ? in_if.op_cin : cin_q;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          in_ready_d = 1'b1;
        end
        default: begin
          if (state_q == ST_SHIFT && last_bit_q) begin
            state_d = ST_DONE;
            done_d = 1'b1;
          end else begin
            state_d = ST_SHIFT;
            emit = 1'b1;
            sa_a_d = a0;
            sa_b_d = b0;
            sa_cin_d = (cnt_q == '0) ? cin_q : 1'b0;
            bit_valid_d = 1'b1;
            last_bit_d = cnt_q == CW'(N - 1);
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      cin_q <= 1'b0;
      in_ready_q <= 1'b0;
      sa_clr_q <= 1'b1;
      sa_a_q <= 1'b0;
      sa_b_q <= 1'b0;
      sa_cin_q <= 1'b0;
      bit_valid_q <= 1'b0;
      last_bit_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cin_q <= cin_d;
      in_ready_q <= in_ready_d;
      sa_clr_q <= sa_clr_d;
      sa_a_q <= sa_a_d;
      sa_b_q <= sa_b_d;
      sa_cin_q <= sa_cin_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q <= last_bit_d;
      done_q <= done_d;
    end
  assign in_if.in_ready = in_ready_q;
  assign sa_clr = sa_clr_q;
  assign sa_a = sa_a_q;
  assign sa_b = sa_b_q;
  assign sa_cin = sa_cin_q;
  assign bit_valid = bit_valid_q;
  assign last_bit = last_bit_q;
  assign done = done_q;
endmodule

// File: tb/tb_sa_operand_serializer.sv
// tb_sa_operand_serializer: directed table, corner sequences and random words against an arithmetic model.
module tb_sa_operand_serializer;
  localparam int W = 4;
`ifdef SA_SER_SIGN_EXT_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [5:0]   sum;
  } vec_t;
  logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
  logic sa_clr, sa_a, sa_b, sa_cin, bit_valid, last_bit, done;
  int checks = 0, errors = 0, cyc = 0;
  sa_operand_serializer_if #(.WIDTH(W)) bus ();
  sa_operand_serializer #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_if(bus), .flush(flush), .sa_clr(sa_clr), .sa_a(sa_a),
    .sa_b(sa_b), .sa_cin(sa_cin), .bit_valid(bit_valid), .last_bit(last_bit), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic logic [7:0] outs();
    return {bit_valid, sa_a, sa_b, sa_cin, last_bit, sa_clr, done, bus.in_ready};
  endfunction
  function automatic logic [NB-1:0] ext(input logic [W-1:0] v);
`ifdef SA_SER_SIGN_EXT_EN
    return NB'($signed(v));
`else
    return v;
`endif
  endfunction
  function automatic logic [5:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
`ifdef SA_SER_SIGN_EXT_EN
    int s;
    s = int'($signed(a)) + int'($signed(b)) + int'(c);
    return 6'(s) & 6'((1 << NB) - 1);
`else
    return 6'(a) + 6'(b) + 6'(c);
`endif
  endfunction
  task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic hold,
                          input logic [5:0] exp, input string n, output int t_acc);
    logic [NB-1:0] xa, xb;
    logic [5:0] col;
    logic carry;
    int i;
    xa = ext(a);
    xb = ext(b);
    col = '0;
    carry = 1'b0;
    t_acc = 0;
    bus.in_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    bus.op_cin = c;
    i = 0;
    while (!bus.in_ready && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready stayed 0 for 50 cycles, expected 1", n);
      bus.in_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    @(posedge clk);
    #1;
    bus.in_valid = hold;
    bus.op_a = ~a;
    bus.op_b = ~b;
    bus.op_cin = ~c;
    @(negedge clk);
    chk({n, "_clr"}, outs(), 8'b0000_0100);
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      chk({n, "_bit"}, outs(), {1'b1, xa[k], xb[k], (k == 0) ? c : 1'b0, k == NB - 1, 3'b000});
      {carry, col[k]} = 2'(sa_a) + 2'(sa_b) + 2'(sa_cin) + 2'(carry);
    end
`ifndef SA_SER_SIGN_EXT_EN
    col[NB] = carry;
`endif
    @(negedge clk);
    chk({n, "_done"}, outs(), 8'b0000_0010);
    @(negedge clk);
    chk({n, "_idle"}, outs(), 8'b0000_0001);
    chk({n, "_sum"}, col, exp);
  endtask
  task automatic no_done(input string n);
    logic seen;
    seen = 1'b0;
    repeat (NB + 3) begin
      @(negedge clk);
      seen |= done;
    end
    chk({n, "_no_done"}, seen, 1'b0);
    chk({n, "_idle"}, outs(), 8'b0000_0001);
  endtask
  task automatic start_and_reach_bit1(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    bus.op_cin = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bit1_live", bit_valid, 1'b1);
  endtask
  initial begin
    vec_t tbl[5];
    int t1, t2;
    logic [W-1:0] ra, rb;
    logic rc;
`ifdef SA_SER_SIGN_EXT_EN
    tbl[0] = '{4'b1111, 4'b0011, 1'b0, 6'b000010};
    tbl[1] = '{4'b1111, 4'b1101, 1'b1, 6'b011101};
    tbl[2] = '{4'b0111, 4'b0111, 1'b0, 6'b001110};
    tbl[3] = '{4'b1000, 4'b1000, 1'b0, 6'b010000};
    tbl[4] = '{4'b0111, 4'b1000, 1'b1, 6'b000000};
`else
    tbl[0] = '{4'b1111, 4'b1101, 1'b1, 6'b011101};
    tbl[1] = '{4'b0000, 4'b0000, 1'b0, 6'b000000};
    tbl[2] = '{4'b1010, 4'b0101, 1'b0, 6'b001111};
    tbl[3] = '{4'b1000, 4'b1000, 1'b1, 6'b010001};
    tbl[4] = '{4'b0001, 4'b1111, 1'b0, 6'b010000};
`endif
    bus.in_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.op_cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", outs(), 8'b0000_0100);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", outs(), 8'b0000_0001);
    for (int i = 0; i < 5; i++) run_word(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, tbl[i].sum, "vec", t1);
    run_word(4'b0110, 4'b0011, 1'b1, 1'b1, model_sum(4'b0110, 4'b0011, 1'b1), "b2b_first", t1);
    run_word(4'b1001, 4'b0111, 1'b0, 1'b0, model_sum(4'b1001, 4'b0111, 1'b0), "b2b_second", t2);
    chk("b2b_spacing", t2 - t1, NB + 3);
    start_and_reach_bit1(4'b0101, 4'b0011);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_shift", outs(), 8'b0000_0101);
    no_done("flush");
    bus.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_idle", outs(), 8'b0000_0001);
    bus.in_valid = 1'b0;
    flush = 1'b0;
    run_word(4'b1100, 4'b0110, 1'b1, 1'b0, model_sum(4'b1100, 4'b0110, 1'b1), "post_flush", t1);
    start_and_reach_bit1(4'b1011, 4'b0110);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", outs(), 8'b0000_0100);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("release_ready", outs(), 8'b0000_0001);
    no_done("reset");
    run_word(4'b0111, 4'b1110, 1'b0, 1'b0, model_sum(4'b0111, 4'b1110, 1'b0), "post_reset", t1);
    repeat (20) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_word(ra, rb, rc, 1'($urandom), model_sum(ra, rb, rc), "rand", t1);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
